// File: rtl/muldiv_sequencer.sv
// Iterative signed multiply (radix-2 Booth) / divide (restoring) unit with its sequencing FSM.
// state | meaning: IDLE wait for start; MULT Booth step; DIV restoring step; FIX sign correction; DONE result pulse
module muldiv_sequencer #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic             op,
   input  logic [WIDTH-1:0] src_a,
   input  logic [WIDTH-1:0] src_b,
   output logic             busy,
   output logic             done,
   output logic             hilo_write,
   output logic             div_zero,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

   localparam int CW = $clog2(WIDTH + 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_MULT,
      S_DIV,
      S_FIX,
      S_DONE
   } state_t;

   state_t               r_state;
   logic [CW-1:0]        r_cnt;
   logic [WIDTH-1:0]     r_mcand;
   logic [2*WIDTH-1:0]   r_prod;
   logic                 r_booth;
   logic [WIDTH-1:0]     r_divisor;
   logic [WIDTH-1:0]     r_rem;
   logic [WIDTH-1:0]     r_quo;
   logic                 r_sign_a;
   logic                 r_sign_b;
   logic [WIDTH-1:0]     r_hi;
   logic [WIDTH-1:0]     r_lo;
   logic                 r_done;
   logic                 r_hilo_write;
   logic                 r_div_zero;

   logic [CW-1:0]        w_cnt_dec;
   logic [WIDTH:0]       w_upper;
   logic [WIDTH:0]       w_mcand_x;
   logic [WIDTH:0]       w_booth_sum;
   logic [2*WIDTH-1:0]   w_prod_next;
   logic [WIDTH:0]       w_shift;
   logic                 w_trial_ok;
   logic [WIDTH-1:0]     w_rem_next;
   logic [WIDTH-1:0]     w_quo_next;
   logic [WIDTH-1:0]     w_abs_a;
   logic [WIDTH-1:0]     w_abs_b;
   logic [WIDTH-1:0]     w_quo_fix;
   logic [WIDTH-1:0]     w_rem_fix;

   assign w_cnt_dec = r_cnt - CW'(1);

   // Upper half is sign-extended by one bit so the add/sub cannot overflow before the shift.
   assign w_upper   = {r_prod[2*WIDTH-1], r_prod[2*WIDTH-1:WIDTH]};
   assign w_mcand_x = {r_mcand[WIDTH-1], r_mcand};

   always_comb begin
      w_booth_sum = w_upper;
      case ({r_prod[0], r_booth})
         2'b01:   w_booth_sum = w_upper + w_mcand_x;
         2'b10:   w_booth_sum = w_upper - w_mcand_x;
         default: w_booth_sum = w_upper;
      endcase
   end

   assign w_prod_next = {w_booth_sum, r_prod[WIDTH-1:1]};

   // The dividend magnitude sits in r_quo and shifts into the remainder one bit per step.
   assign w_shift    = {r_rem, r_quo[WIDTH-1]};
   assign w_trial_ok = (w_shift >= {1'b0, r_divisor});
   assign w_rem_next = w_trial_ok ? WIDTH'(w_shift - {1'b0, r_divisor}) : WIDTH'(w_shift);
   assign w_quo_next = {r_quo[WIDTH-2:0], w_trial_ok};

   assign w_abs_a = src_a[WIDTH-1] ? (~src_a + 1'b1) : src_a;
   assign w_abs_b = src_b[WIDTH-1] ? (~src_b + 1'b1) : src_b;

   assign w_quo_fix = (r_sign_a ^ r_sign_b) ? (~r_quo + 1'b1) : r_quo;
   assign w_rem_fix = r_sign_a ? (~r_rem + 1'b1) : r_rem;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state      <= S_IDLE;
         r_cnt        <= '0;
         r_mcand      <= '0;
         r_prod       <= '0;
         r_booth      <= 1'b0;
         r_divisor    <= '0;
         r_rem        <= '0;
         r_quo        <= '0;
         r_sign_a     <= 1'b0;
         r_sign_b     <= 1'b0;
         r_hi         <= '0;
         r_lo         <= '0;
         r_done       <= 1'b0;
         r_hilo_write <= 1'b0;
         r_div_zero   <= 1'b0;
      end else begin
         r_done       <= 1'b0;
         r_hilo_write <= 1'b0;
         r_div_zero   <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (start) begin
                  if (!op) begin
                     r_mcand <= src_a;
                     r_prod  <= {{WIDTH{1'b0}}, src_b};
                     r_booth <= 1'b0;
                     r_cnt   <= CW'(WIDTH);
                     r_state <= S_MULT;
                  end else if (src_b != '0) begin
                     r_divisor <= w_abs_b;
                     r_quo     <= w_abs_a;
                     r_rem     <= '0;
                     r_sign_a  <= src_a[WIDTH-1];
                     r_sign_b  <= src_b[WIDTH-1];
                     r_cnt     <= CW'(WIDTH);
                     r_state   <= S_DIV;
                  end else begin
                     r_done     <= 1'b1;
                     r_div_zero <= 1'b1;
                     r_state    <= S_DONE;
                  end
               end
            end
            S_MULT: begin
               r_prod  <= w_prod_next;
               r_booth <= r_prod[0];
               r_cnt   <= w_cnt_dec;
               if (w_cnt_dec == '0) begin
                  r_hi         <= w_prod_next[2*WIDTH-1:WIDTH];
                  r_lo         <= w_prod_next[WIDTH-1:0];
                  r_done       <= 1'b1;
                  r_hilo_write <= 1'b1;
                  r_state      <= S_DONE;
               end
            end
            S_DIV: begin
               r_rem <= w_rem_next;
               r_quo <= w_quo_next;
               r_cnt <= w_cnt_dec;
               if (w_cnt_dec == '0) begin
                  r_state <= S_FIX;
               end
            end
            S_FIX: begin
               r_hi         <= w_rem_fix;
               r_lo         <= w_quo_fix;
               r_done       <= 1'b1;
               r_hilo_write <= 1'b1;
               r_state      <= S_DONE;
            end
            S_DONE: begin
               r_state <= S_IDLE;
            end
            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   assign busy       = (r_state != S_IDLE);
   assign done       = r_done;
   assign hilo_write = r_hilo_write;
   assign div_zero   = r_div_zero;
   assign hi         = r_hi;
   assign lo         = r_lo;

endmodule
